// File: rtl/mem_access_ctrl.sv
// Memory access sequencer for a 3x3 window filter: gathers READS_PER_WIN pixels, hands the window
// to the filter, writes the result back. Define MEM_TIMEOUT_EN to enable the bus-ack watchdog.
module mem_access_ctrl #(
  parameter int DATA_W        = 8,
  parameter int READS_PER_WIN = 9,
  parameter int TIMEOUT_CYC   = 16
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            i_start,
  output logic                            o_inc_raddr,
  output logic                            o_inc_waddr,
  input  logic                            i_r_ready,
  input  logic                            i_w_ready,
  input  logic [31:0]                     i_raddr,
  input  logic [31:0]                     i_waddr,
  input  logic                            i_done,
  output logic [31:0]                     o_mem_addr,
  output logic                            o_mem_read,
  output logic                            o_mem_write,
  output logic [DATA_W-1:0]               o_mem_wdata,
  input  logic [DATA_W-1:0]               i_mem_rdata,
  input  logic                            i_mem_ack,
  output logic [READS_PER_WIN*DATA_W-1:0] o_window,
  output logic                            o_window_valid,
  input  logic [DATA_W-1:0]               i_result,
  input  logic                            i_result_valid,
  output logic                            o_busy,
  output logic                            o_finished,
  output logic                            o_error
);

  localparam int IDX_W = (READS_PER_WIN > 1) ? $clog2(READS_PER_WIN) : 1;

  typedef enum logic [3:0] {
    IDLE, RINC, RWAIT, RBUS, WINDOW, WINC, WWAIT, WBUS, FIN
  } state_t;

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx;
  logic               last_flag;
  logic [DATA_W-1:0]  win_q [READS_PER_WIN];
  logic               timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Watchdog restarts on every entry to a bus phase; an ack in the final cycle still wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt  <= '0;
      o_error <= 1'b0;
    end else begin
      if ((state == RBUS || state == WBUS) && !i_mem_ack)
        wd_cnt <= wd_cnt + CNT_W'(1);
      else
        wd_cnt <= '0;
      if (timeout_hit)
        o_error <= 1'b1;
    end
  end

  assign timeout_hit = (state == RBUS || state == WBUS) && !i_mem_ack &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = (TIMEOUT_CYC < 0);
  assign o_error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (i_start) next_state = RINC;
      RINC:   next_state = RWAIT;
      RWAIT:  if (i_r_ready) next_state = RBUS;
      RBUS: begin
        if (i_mem_ack)
          next_state = (idx == IDX_W'(READS_PER_WIN - 1)) ? WINDOW : RINC;
        else if (timeout_hit)
          next_state = FIN;
      end
      WINDOW: if (i_result_valid) next_state = WINC;
      WINC:   next_state = WWAIT;
      WWAIT:  if (i_w_ready) next_state = WBUS;
      WBUS: begin
        if (i_mem_ack)
          next_state = last_flag ? FIN : RINC;
        else if (timeout_hit)
          next_state = FIN;
      end
      FIN:    if (!i_start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address, pixel and result capture happen only in the state that owns each handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx         <= '0;
      last_flag   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      for (int i = 0; i < READS_PER_WIN; i++) win_q[i] <= '0;
    end else begin
      case (state)
        IDLE: idx <= '0;
        RWAIT: if (i_r_ready) o_mem_addr <= i_raddr;
        RBUS: begin
          if (i_mem_ack) begin
            for (int i = 0; i < READS_PER_WIN; i++)
              if (idx == IDX_W'(i)) win_q[i] <= i_mem_rdata;
            idx <= idx + IDX_W'(1);
          end
        end
        WINDOW: begin
          if (i_result_valid) begin
            o_mem_wdata <= i_result;
            idx         <= '0;
          end
        end
        WWAIT: begin
          if (i_w_ready) begin
            o_mem_addr <= i_waddr;
            last_flag  <= i_done;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_window = '0;
    for (int i = 0; i < READS_PER_WIN; i++)
      o_window[i*DATA_W +: DATA_W] = win_q[i];
  end

  assign o_inc_raddr    = (state == RINC);
  assign o_inc_waddr    = (state == WINC);
  assign o_mem_read     = (state == RBUS);
  assign o_mem_write    = (state == WBUS);
  assign o_window_valid = (state == WINDOW);
  assign o_finished     = (state == FIN);
  assign o_busy         = (state != IDLE) && (state != FIN);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: models the address counter, memory bus and filter,
// queues expected addresses/data as stimulus is driven and compares when the DUT acts on them.
module tb_mem_access_ctrl;

  localparam int DATA_W = 8;
  localparam int RPW    = 9;
  localparam int WIN_W  = RPW * DATA_W;

  logic              clk = 1'b0;
  logic              n_rst, i_start, i_r_ready, i_w_ready, i_done, i_mem_ack, i_result_valid;
  logic [31:0]       i_raddr, i_waddr, o_mem_addr;
  logic [DATA_W-1:0] i_mem_rdata, i_result, o_mem_wdata;
  logic [WIN_W-1:0]  o_window;
  logic              o_inc_raddr, o_inc_waddr, o_mem_read, o_mem_write;
  logic              o_window_valid, o_busy, o_finished, o_error;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(DATA_W), .READS_PER_WIN(RPW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start),
    .o_inc_raddr(o_inc_raddr), .o_inc_waddr(o_inc_waddr),
    .i_r_ready(i_r_ready), .i_w_ready(i_w_ready),
    .i_raddr(i_raddr), .i_waddr(i_waddr), .i_done(i_done),
    .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_window(o_window), .o_window_valid(o_window_valid),
    .i_result(i_result), .i_result_valid(i_result_valid),
    .o_busy(o_busy), .o_finished(o_finished), .o_error(o_error)
  );

  int checks = 0;
  int failures = 0;
  int cycles = 0;

  // responder configuration
  int ack_lat, result_lat, spurious_en, frame_windows;

  // responder / observation state
  logic             r_pend, w_pend;
  int               rd_cyc, wr_cyc, win_cyc, build_n, reads_since_win, win_count;
  int               rd_len_min, rd_len_max, win_len_last, addr_unstable, overlap, writes_done;
  bit               fin_seen;
  logic [31:0]      raddr_next = 32'h0000_1000;
  logic [31:0]      waddr_next = 32'h0000_8000;
  logic [31:0]      cur_rd_addr;
  logic [WIN_W-1:0] build;

  logic [31:0]       exp_raddr[$], obs_raddr[$], exp_waddr[$], obs_waddr[$];
  logic [DATA_W-1:0] exp_wdata[$], obs_wdata[$], data_q[$], res_q[$];
  logic [WIN_W-1:0]  exp_win[$], obs_win[$];
  int                rpw_q[$];

  task automatic clear_model();
    r_pend = 0; w_pend = 0; rd_cyc = 0; wr_cyc = 0; win_cyc = 0; build_n = 0;
    reads_since_win = 0; win_count = 0; fin_seen = 0; addr_unstable = 0;
    rd_len_min = 1000; rd_len_max = 0; win_len_last = 0;
    exp_raddr.delete(); obs_raddr.delete(); exp_waddr.delete(); obs_waddr.delete();
    exp_wdata.delete(); obs_wdata.delete(); exp_win.delete(); obs_win.delete();
    data_q.delete(); res_q.delete(); rpw_q.delete();
  endtask

  // One clock: sample DUT 1ns after the edge, then drive responder inputs for the next edge.
  task automatic tick();
    logic [DATA_W-1:0] d, rv;
    @(posedge clk); #1;
    cycles++;
    if (cycles > 50000) begin
      failures++;
      $display("[TB] FAIL cycle_guard: ran %0d cycles, required under 50000", cycles);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    i_r_ready = 0; i_w_ready = 0; i_mem_ack = 0; i_result_valid = 0; i_done = 0;
    if (o_mem_read && o_mem_write) overlap++;
    if (o_finished) fin_seen = 1;

    if (r_pend) begin
      i_r_ready = 1; i_raddr = raddr_next;
      exp_raddr.push_back(raddr_next);
      raddr_next += 32'd4; r_pend = 0;
    end
    if (o_inc_raddr) r_pend = 1;
    if (w_pend) begin
      i_w_ready = 1; i_waddr = waddr_next;
      i_done = (win_count == frame_windows - 1);
      exp_waddr.push_back(waddr_next);
      waddr_next += 32'd4; win_count++; w_pend = 0;
    end
    if (o_inc_waddr) w_pend = 1;

    if (o_mem_read) begin
      if (rd_cyc == 0) begin
        obs_raddr.push_back(o_mem_addr);
        cur_rd_addr = o_mem_addr;
      end else if (o_mem_addr !== cur_rd_addr) addr_unstable++;
      rd_cyc++;
      if (ack_lat != 0 && rd_cyc == ack_lat) begin
        d = (data_q.size() > 0) ? data_q.pop_front() : DATA_W'($urandom_range(0, 255));
        i_mem_ack = 1; i_mem_rdata = d;
        build = {d, build[WIN_W-1:DATA_W]};
        build_n++; reads_since_win++;
        if (build_n == RPW) begin
          exp_win.push_back(build);
          build_n = 0;
        end
      end
    end else if (rd_cyc != 0) begin
      if (rd_cyc < rd_len_min) rd_len_min = rd_cyc;
      if (rd_cyc > rd_len_max) rd_len_max = rd_cyc;
      rd_cyc = 0;
    end

    if (o_mem_write) begin
      if (wr_cyc == 0) begin
        obs_waddr.push_back(o_mem_addr);
        obs_wdata.push_back(o_mem_wdata);
      end
      wr_cyc++;
      if (ack_lat != 0 && wr_cyc == ack_lat) begin
        i_mem_ack = 1; writes_done++;
      end
    end else wr_cyc = 0;

    if (o_window_valid) begin
      if (win_cyc == 0) begin
        obs_win.push_back(o_window);
        rpw_q.push_back(reads_since_win);
        reads_since_win = 0;
      end
      win_cyc++;
      if (spurious_en != 0 && win_cyc == 1) begin
        i_mem_ack = 1; i_mem_rdata = 8'hEE;
      end
      if (win_cyc == result_lat) begin
        rv = (res_q.size() > 0) ? res_q.pop_front() : DATA_W'($urandom_range(0, 255));
        i_result = rv; i_result_valid = 1;
        exp_wdata.push_back(rv);
      end
    end else if (win_cyc != 0) begin
      win_len_last = win_cyc;
      win_cyc = 0;
    end
  endtask

  task automatic do_reset(input bit start);
    n_rst = 0; i_start = start;
    clear_model();
    repeat (2) tick();
    clear_model();
    n_rst = 1;
  endtask

  task automatic test_reset();
    clear_model();
    repeat (3) tick();
    checks++;
    if ({o_inc_raddr, o_inc_waddr, o_mem_read, o_mem_write, o_window_valid, o_busy, o_finished, o_error} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b required 00000000",
               {o_inc_raddr, o_inc_waddr, o_mem_read, o_mem_write, o_window_valid, o_busy, o_finished, o_error});
    end
    checks++;
    if (o_mem_addr !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_addr: got %h required 0", o_mem_addr);
    end
    checks++;
    if (o_mem_wdata !== 8'h0) begin
      failures++; $display("[TB] FAIL reset_wdata: got %h required 0", o_mem_wdata);
    end
    checks++;
    if (o_window !== '0) begin
      failures++; $display("[TB] FAIL reset_window: got %h required 0", o_window);
    end
    i_start = 1;
    tick();
    checks++;
    if (o_inc_raddr !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_hold_start: inc=%b busy=%b required 0 0", o_inc_raddr, o_busy);
    end
  endtask

  task automatic test_first_frame();
    int n;
    clear_model();
    for (int k = 0; k < RPW; k++) data_q.push_back(DATA_W'((k + 1) * 17));
    res_q.push_back(8'hAB);
    ack_lat = 1; result_lat = 1; spurious_en = 0; frame_windows = 2;
    i_start = 1;
    n_rst = 1;
    tick();
    checks++;
    if (o_inc_raddr !== 1'b1) begin
      failures++; $display("[TB] FAIL first_inc_pulse: got %b required 1", o_inc_raddr);
    end
    tick();
    checks++;
    if (o_inc_raddr !== 1'b0) begin
      failures++; $display("[TB] FAIL inc_pulse_width: got %b required 0", o_inc_raddr);
    end
    n = 0;
    while (!o_finished && n < 400) begin tick(); n++; end
    checks++;
    if (o_finished !== 1'b1 || o_busy !== 1'b0) begin
      failures++; $display("[TB] FAIL frame_end: finished=%b busy=%b required 1 0", o_finished, o_busy);
    end
    checks++;
    if (rpw_q.size() != 2) begin
      failures++; $display("[TB] FAIL window_count: got %0d required 2", rpw_q.size());
    end
    while (rpw_q.size() > 0) begin
      n = rpw_q.pop_front();
      checks++;
      if (n != RPW) begin
        failures++; $display("[TB] FAIL reads_per_window: got %0d required %0d", n, RPW);
      end
    end
    checks++;
    if (obs_win.size() < 1 || obs_win[0] !== 72'h998877665544332211) begin
      failures++; $display("[TB] FAIL window_pattern: got %h required 998877665544332211",
                           (obs_win.size() > 0) ? obs_win[0] : '0);
    end
    checks++;
    if (obs_raddr.size() != exp_raddr.size() || exp_raddr.size() != 2 * RPW) begin
      failures++; $display("[TB] FAIL read_count: got %0d required %0d", obs_raddr.size(), exp_raddr.size());
    end
    while (exp_raddr.size() > 0 && obs_raddr.size() > 0) begin
      logic [31:0] e, o;
      e = exp_raddr.pop_front(); o = obs_raddr.pop_front();
      checks++;
      if (o !== e) begin
        failures++; $display("[TB] FAIL read_addr: got %h required %h", o, e);
      end
    end
    while (exp_win.size() > 0 && obs_win.size() > 0) begin
      logic [WIN_W-1:0] e, o;
      e = exp_win.pop_front(); o = obs_win.pop_front();
      checks++;
      if (o !== e) begin
        failures++; $display("[TB] FAIL window_data: got %h required %h", o, e);
      end
    end
    checks++;
    if (obs_waddr.size() != 2 || exp_waddr.size() != 2 || exp_wdata.size() != 2) begin
      failures++; $display("[TB] FAIL write_count: got %0d required 2", obs_waddr.size());
    end
    while (exp_waddr.size() > 0 && obs_waddr.size() > 0 && exp_wdata.size() > 0 && obs_wdata.size() > 0) begin
      logic [31:0] ea, oa;
      logic [DATA_W-1:0] ed, od;
      ea = exp_waddr.pop_front(); oa = obs_waddr.pop_front();
      ed = exp_wdata.pop_front(); od = obs_wdata.pop_front();
      checks++;
      if (oa !== ea || od !== ed) begin
        failures++; $display("[TB] FAIL write_txn: got addr %h data %h required addr %h data %h", oa, od, ea, ed);
      end
    end
    i_start = 0;
    tick();
    checks++;
    if ({o_finished, o_busy, o_inc_raddr} !== 3'b000) begin
      failures++; $display("[TB] FAIL return_idle: got %b required 000", {o_finished, o_busy, o_inc_raddr});
    end
  endtask

  task automatic test_ack_delay();
    int n, w0;
    clear_model();
    ack_lat = 5; result_lat = 3; spurious_en = 1; frame_windows = 1;
    w0 = writes_done;
    i_start = 1;
    repeat (3) tick();
    i_start = 0;
    n = 0;
    while (!fin_seen && n < 600) begin tick(); n++; end
    checks++;
    if (!fin_seen) begin
      failures++; $display("[TB] FAIL delay_frame_end: finished never seen within 600 cycles");
    end
    checks++;
    if (rd_len_min != 5 || rd_len_max != 5) begin
      failures++; $display("[TB] FAIL read_hold_len: got min %0d max %0d required 5", rd_len_min, rd_len_max);
    end
    checks++;
    if (addr_unstable != 0) begin
      failures++; $display("[TB] FAIL read_addr_stable: got %0d changes required 0", addr_unstable);
    end
    checks++;
    if (win_len_last != 3) begin
      failures++; $display("[TB] FAIL window_hold: got %0d cycles required 3", win_len_last);
    end
    checks++;
    if (rpw_q.size() != 1 || rpw_q[0] != RPW) begin
      failures++; $display("[TB] FAIL delay_reads: got %0d windows required 1 of %0d reads", rpw_q.size(), RPW);
    end
    checks++;
    if (writes_done - w0 != 1) begin
      failures++; $display("[TB] FAIL delay_write_count: got %0d required 1", writes_done - w0);
    end
    checks++;
    if (obs_wdata.size() != 1 || exp_wdata.size() != 1 || obs_waddr.size() != 1 || exp_waddr.size() != 1 ||
        obs_wdata[0] !== exp_wdata[0] || obs_waddr[0] !== exp_waddr[0]) begin
      failures++; $display("[TB] FAIL delay_write_txn: got %0d writes required 1 matching scoreboard", obs_wdata.size());
    end
    tick();
    checks++;
    if ({o_finished, o_busy} !== 2'b00) begin
      failures++; $display("[TB] FAIL delay_idle: got %b required 00", {o_finished, o_busy});
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_model();
    ack_lat = 0; result_lat = 1; spurious_en = 0; frame_windows = 1;
    i_start = 1;
    n = 0;
    while (!o_mem_read && n < 20) begin tick(); n++; end
    n = 1;
    while (o_mem_read && n < 130) begin
      tick();
      if (o_mem_read) n++;
    end
`ifdef MEM_TIMEOUT_EN
    checks++;
    if (n != 16) begin
      failures++; $display("[TB] FAIL timeout_len: got %0d cycles required 16", n);
    end
    checks++;
    if ({o_mem_read, o_error, o_finished} !== 3'b011) begin
      failures++; $display("[TB] FAIL timeout_state: got %b required 011", {o_mem_read, o_error, o_finished});
    end
`else
    checks++;
    if (n != 130 || o_mem_read !== 1'b1) begin
      failures++; $display("[TB] FAIL no_watchdog_hold: got %0d cycles read=%b required 130 1", n, o_mem_read);
    end
    checks++;
    if (o_error !== 1'b0) begin
      failures++; $display("[TB] FAIL no_watchdog_error: got %b required 0", o_error);
    end
`endif
    do_reset(0);
    tick();
    checks++;
    if (o_error !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("[TB] FAIL timeout_recover: error=%b busy=%b required 0 0", o_error, o_busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    clear_model();
    ack_lat = 3; result_lat = 1; spurious_en = 0; frame_windows = 1;
    i_start = 1;
    n = 0;
    while (!o_mem_write && n < 200) begin tick(); n++; end
    checks++;
    if (o_mem_write !== 1'b1) begin
      failures++; $display("[TB] FAIL reach_wbus: got %b required 1", o_mem_write);
    end
    #3 n_rst = 0;
    #1;
    checks++;
    if ({o_inc_raddr, o_inc_waddr, o_mem_read, o_mem_write, o_window_valid, o_busy, o_finished, o_error} !== 8'h00) begin
      failures++; $display("[TB] FAIL async_reset_flags: got %b required 00000000",
               {o_inc_raddr, o_inc_waddr, o_mem_read, o_mem_write, o_window_valid, o_busy, o_finished, o_error});
    end
    checks++;
    if (o_mem_addr !== 32'h0 || o_mem_wdata !== 8'h0 || o_window !== '0) begin
      failures++; $display("[TB] FAIL async_reset_data: addr %h wdata %h window %h required 0", o_mem_addr, o_mem_wdata, o_window);
    end
    clear_model();
    tick();
    n_rst = 1;
    tick();
    checks++;
    if (o_inc_raddr !== 1'b1) begin
      failures++; $display("[TB] FAIL restart_inc: got %b required 1", o_inc_raddr);
    end
    n = 0;
    while (!o_finished && n < 400) begin tick(); n++; end
    checks++;
    if (rpw_q.size() != 1 || rpw_q[0] != RPW) begin
      failures++; $display("[TB] FAIL restart_reads: got %0d windows required 1 of %0d reads", rpw_q.size(), RPW);
    end
    checks++;
    if (obs_raddr.size() != RPW || exp_raddr.size() != RPW || obs_raddr[0] !== exp_raddr[0]) begin
      failures++; $display("[TB] FAIL restart_first_addr: got %0d reads required %0d from scoreboard head", obs_raddr.size(), RPW);
    end
    checks++;
    if (obs_wdata.size() != 1 || exp_wdata.size() != 1 || obs_wdata[0] !== exp_wdata[0]) begin
      failures++; $display("[TB] FAIL restart_write: got %0d writes required 1 matching scoreboard", obs_wdata.size());
    end
    checks++;
    if (overlap != 0) begin
      failures++; $display("[TB] FAIL read_write_overlap: got %0d cycles required 0", overlap);
    end
    i_start = 0;
    tick();
  endtask

  initial begin
    n_rst = 0; i_start = 0; i_r_ready = 0; i_w_ready = 0; i_done = 0;
    i_raddr = '0; i_waddr = '0; i_mem_rdata = '0; i_mem_ack = 0;
    i_result = '0; i_result_valid = 0;
    ack_lat = 1; result_lat = 1; spurious_en = 0; frame_windows = 1;
    overlap = 0; writes_done = 0; build = '0; cur_rd_addr = '0;
    $display("[TB] mem_access_ctrl bench start");
    test_reset();
    test_first_frame();
    test_ack_delay();
    test_timeout();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
